instr_buffer: RTL and testbench

- Parametrised successor to the single-word instruction register of the multi-cycle CPU.
- Clocked FIFO of DEPTH instruction words, each tagged with its PC, sitting between instruction memory fetch and the decode/control stage.
- Also holds a registered "current instruction" copy, loaded on each pop, that stays stable while decode and control work on it.
- Adds a valid/ready handshake on both sides, occupancy reporting and a pipeline flush for taken branches and jumps.

---
 rtl/instr_buf_pkg.sv | 48 ++++
 rtl/instr_buf_mem.sv | 29 ++
 rtl/instr_buffer.sv | 92 +++++++++
 tb/tb_instr_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_buf_pkg.sv
// Shared constants for the instruction buffer and the decode stage behind it:
// instruction field positions, the NOP encoding and field-extraction helpers.
package instr_buf_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t split_fields(input logic [31:0] instr);
        instr_fields_t f;
        f.opcode = instr[OP_HI:OP_LO];
        f.rs     = instr[RS_HI:RS_LO];
        f.rt     = instr[RT_HI:RT_LO];
        f.rd     = instr[RD_HI:RD_LO];
        f.shamt  = instr[SHAMT_HI:SHAMT_LO];
        f.funct  = instr[FUNCT_HI:FUNCT_LO];
        f.imm    = instr[IMM_HI:IMM_LO];
        return f;
    endfunction

    function automatic logic is_nop(input logic [31:0] instr);
        return instr == NOP_WORD;
    endfunction

endpackage

// File: rtl/instr_buf_mem.sv
// Storage array for the instruction buffer: one synchronous write port and one
// asynchronous read port, each entry holding {instruction, pc}.
module instr_buf_mem #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and count,
    // so clearing the array would only add reset fan-out. Non-blocking writes
    // keep the read port seeing the pre-edge contents within the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_buffer.sv
// Instruction FIFO between fetch and decode, with PC tags, occupancy reporting,
// branch/jump flush and a held "current instruction" register loaded on pop.
module instr_buffer
    import instr_buf_pkg::*;
#(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    output logic          in_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    input  logic          out_ready,
    output logic [IW-1:0] ir_instr,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IW+AW-1:0] head;
    logic             push;
    logic             pop;

    // Handshake outputs depend on registered count only, so no valid/ready
    // signal can loop combinationally through this block.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    instr_buf_mem #(
        .W     (IW + AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata ({in_instr, in_pc}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign out_instr = head[IW+AW-1:AW];
    assign out_pc    = head[AW-1:0];

    // NOTE: ir_* are only assigned on pop inside a clocked block, so the hold
    // case is a flop enable rather than a latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ir_instr <= IW'(NOP_WORD);
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                ir_instr <= out_instr;
                ir_pc    <= out_pc;
                ir_valid <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus random traffic,
// all checked against a queue-based model by a negedge monitor.
module tb_instr_buffer;

    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic [AW-1:0] in_pc = '0;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready = 1'b0;
    logic [IW-1:0] ir_instr;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    entry_t        model_q[$];
    logic [IW-1:0] m_ir_instr = '0;
    logic [AW-1:0] m_ir_pc = '0;
    logic          m_ir_valid = 1'b0;

    instr_buffer #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .ir_instr  (ir_instr),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs with the model, then advance the model by what
    // the coming rising edge will do with the (now stable) inputs.
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            m_ir_instr = '0;
            m_ir_pc    = '0;
            m_ir_valid = 1'b0;
        end else begin
            automatic int  sz = model_q.size();
            automatic logic will_push = in_valid && (sz < DEPTH);
            automatic logic will_pop  = out_ready && (sz > 0);
            check("mon_count",     64'(count),      64'(sz));
            check("mon_in_ready",  64'(in_ready),   64'(sz < DEPTH));
            check("mon_out_valid", 64'(out_valid),  64'(sz > 0));
            check("mon_ir_valid",  64'(ir_valid),   64'(m_ir_valid));
            check("mon_ir_instr",  64'(ir_instr),   64'(m_ir_instr));
            check("mon_ir_pc",     64'(ir_pc),      64'(m_ir_pc));
            if (flush) begin
                model_q.delete();
                m_ir_valid = 1'b0;
            end else begin
                if (will_pop) begin
                    automatic entry_t e = model_q.pop_front();
                    check("mon_out_instr", 64'(out_instr), 64'(e.instr));
                    check("mon_out_pc",    64'(out_pc),    64'(e.pc));
                    m_ir_instr = e.instr;
                    m_ir_pc    = e.pc;
                    m_ir_valid = 1'b1;
                end
                if (will_push) begin
                    model_q.push_back('{instr: in_instr, pc: in_pc});
                end
            end
        end
    end

    // Apply inputs for one cycle; returns at posedge+1 with the new state visible.
    task automatic cyc(input logic v, input logic [IW-1:0] instr, input logic [AW-1:0] pc,
                       input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [AW-1:0] pc;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_count",     64'(count),     64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_ir_valid",  64'(ir_valid),  64'(0));
        check("rst_ir_instr",  64'(ir_instr),  64'(0));

        // Fill, overflow attempt, drain.
        cyc(1, 32'h8C01_0004, 32'h0, 0, 0);
        cyc(1, 32'h8C02_0008, 32'h4, 0, 0);
        cyc(1, 32'h0022_1820, 32'h8, 0, 0);
        cyc(1, 32'hAC03_000C, 32'hC, 0, 0);
        check("full_count",    64'(count),    64'(4));
        check("full_in_ready", 64'(in_ready), 64'(0));
        cyc(1, 32'hDEAD_BEEF, 32'h10, 0, 0);
        check("overflow_count", 64'(count), 64'(4));
        cyc(0, '0, '0, 1, 0);
        check("drain1_ir_instr", 64'(ir_instr), 64'(32'h8C01_0004));
        cyc(0, '0, '0, 1, 0);
        check("drain2_ir_pc", 64'(ir_pc), 64'(32'h4));
        cyc(0, '0, '0, 1, 0);
        cyc(0, '0, '0, 1, 0);
        check("drain4_ir_instr", 64'(ir_instr), 64'(32'hAC03_000C));
        check("drain4_ir_pc",    64'(ir_pc),    64'(32'hC));
        check("drain_count",     64'(count),    64'(0));
        cyc(0, '0, '0, 0, 0);
        check("hold_ir_instr", 64'(ir_instr), 64'(32'hAC03_000C));

        // Simultaneous push/pop at count=2 across pointer wrap.
        for (int i = 4; i < 6; i++) cyc(1, 32'h1000_0000 + 32'(i), 32'(i * 4), 0, 0);
        for (int i = 6; i < 12; i++) cyc(1, 32'h1000_0000 + 32'(i), 32'(i * 4), 1, 0);
        check("pp_count",    64'(count),    64'(2));
        check("pp_ir_instr", 64'(ir_instr), 64'(32'h1000_0009));

        // Flush at count=3 with push and pop requested together.
        cyc(1, 32'h2000_0001, 32'h100, 0, 0);
        check("pre_flush_count", 64'(count), 64'(3));
        cyc(1, 32'h2000_0002, 32'h104, 1, 1);
        check("flush_count",     64'(count),     64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_ir_valid",  64'(ir_valid),  64'(0));
        check("flush_ir_instr",  64'(ir_instr),  64'(32'h1000_0009));
        cyc(1, 32'h0800_0010, 32'h10, 0, 0);
        cyc(0, '0, '0, 1, 0);
        check("post_flush_ir_instr", 64'(ir_instr), 64'(32'h0800_0010));
        check("post_flush_ir_pc",    64'(ir_pc),    64'(32'h10));

        // Async reset between edges at count=2.
        cyc(1, 32'h3000_0001, 32'h200, 0, 0);
        cyc(1, 32'h3000_0002, 32'h204, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count",    64'(count),    64'(0));
        check("async_rst_ir_valid", 64'(ir_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 32'h8C01_0004, 32'h0, 0, 0);
        cyc(0, '0, '0, 1, 0);
        check("resume_ir_instr", 64'(ir_instr), 64'(32'h8C01_0004));

        // Pop attempts on an empty buffer.
        repeat (3) cyc(0, '0, '0, 1, 0);
        check("empty_ir_instr", 64'(ir_instr), 64'(32'h8C01_0004));
        check("empty_ir_pc",    64'(ir_pc),    64'(32'h0));
        check("empty_count",    64'(count),    64'(0));

        // Random traffic, checked by the monitor.
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, pc,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            pc = pc + 32'd4;
        end
        repeat (DEPTH + 1) cyc(0, '0, '0, 1, 0);
        check("final_count", 64'(count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
